// File: rtl/wishbone_slave_pipelined_if.sv
// rtl/wishbone_slave_pipelined_if.sv - Wishbone B4 pipelined bus signal bundle
interface wishbone_slave_pipelined_if #(
   parameter int DATA_WIDTH = 32
);
   logic [31:0]             wb_adr_i;
   logic [DATA_WIDTH-1:0]   wb_dat_i;
   logic [DATA_WIDTH-1:0]   wb_dat_o;
   logic [DATA_WIDTH/8-1:0] wb_sel_i;
   logic                    wb_we_i;
   logic                    wb_stb_i;
   logic                    wb_cyc_i;
   logic                    wb_ack_o;
   logic                    wb_err_o;
   logic                    wb_stall_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
   );
endinterface

// File: rtl/wishbone_slave_pipelined.sv
// rtl/wishbone_slave_pipelined.sv - Wishbone B4 pipelined memory slave with fixed response latency
module wishbone_slave_pipelined #(
   parameter int          DATA_WIDTH      = 32,
   parameter int          DEPTH           = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          LATENCY         = 1,
   parameter int          MAX_OUTSTANDING = 4
) (
   input logic clk_i,
   input logic rst_i,
   input logic stall_request_i,
   wishbone_slave_pipelined_if.slave wb
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int SHIFT = $clog2(NB);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]         count;
   logic [LATENCY-1:0]    pipe_valid;
   logic [LATENCY-1:0]    pipe_err;
   logic [DATA_WIDTH-1:0] pipe_data [LATENCY];

   logic [31:0]   offset;
   logic [31:0]   word_off;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          accept;
   logic          respond;

   always_comb begin
      offset   = wb.wb_adr_i - BASE_ADDR;
      word_off = offset >> SHIFT;
      in_range = (wb.wb_adr_i >= BASE_ADDR) && (word_off < 32'(DEPTH));
      idx      = word_off[AW-1:0];
   end

   // Registered count only: a response in this cycle does not free a slot until the next edge.
   assign wb.wb_stall_o = stall_request_i || (count == CW'(MAX_OUTSTANDING));
   assign accept        = wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_stall_o && !rst_i;
   assign respond       = pipe_valid[LATENCY-1];

   always_ff @(posedge clk_i) begin
      if (accept && in_range && wb.wb_we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (wb.wb_sel_i[b]) mem[idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
         end
      end
   end

   // Stage 0 is filled at the acceptance edge; the last stage drives the bus.
   always_ff @(posedge clk_i) begin
      if (rst_i || !wb.wb_cyc_i) begin
         count      <= '0;
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
      end else begin
         count         <= count + CW'(accept) - CW'(respond);
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept && !in_range;
         pipe_data[0]  <= (accept && in_range && !wb.wb_we_i) ? mem[idx] : '0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   assign wb.wb_ack_o = respond && !pipe_err[LATENCY-1];
   assign wb.wb_err_o = respond && pipe_err[LATENCY-1];
   assign wb.wb_dat_o = pipe_data[LATENCY-1];
endmodule

// File: tb/tb_wishbone_slave_pipelined.sv
// tb/tb_wishbone_slave_pipelined.sv - scoreboard bench for the pipelined Wishbone slave
module tb_wishbone_slave_pipelined;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cyc, stb, we, streq;
   logic [31:0] adr, wdat;
   logic [3:0]  sel;
   logic [1:0]  dsel;

   wishbone_slave_pipelined_if #(.DATA_WIDTH(32)) if_a ();
   wishbone_slave_pipelined_if #(.DATA_WIDTH(32)) if_b ();
   wishbone_slave_pipelined_if #(.DATA_WIDTH(32)) if_c ();

   assign {if_a.wb_adr_i, if_a.wb_dat_i, if_a.wb_sel_i, if_a.wb_we_i, if_a.wb_stb_i} = {adr, wdat, sel, we, stb};
   assign {if_b.wb_adr_i, if_b.wb_dat_i, if_b.wb_sel_i, if_b.wb_we_i, if_b.wb_stb_i} = {adr, wdat, sel, we, stb};
   assign {if_c.wb_adr_i, if_c.wb_dat_i, if_c.wb_sel_i, if_c.wb_we_i, if_c.wb_stb_i} = {adr, wdat, sel, we, stb};
   assign if_a.wb_cyc_i = cyc && (dsel == 2'd0);
   assign if_b.wb_cyc_i = cyc && (dsel == 2'd1);
   assign if_c.wb_cyc_i = cyc && (dsel == 2'd2);

   wishbone_slave_pipelined #(.DATA_WIDTH(32), .LATENCY(1), .MAX_OUTSTANDING(4)) dut_a (
      .clk_i(clk), .rst_i(rst), .stall_request_i(streq), .wb(if_a));
   wishbone_slave_pipelined #(.DATA_WIDTH(32), .LATENCY(3), .MAX_OUTSTANDING(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .stall_request_i(streq), .wb(if_b));
   wishbone_slave_pipelined #(.DATA_WIDTH(32), .LATENCY(4), .MAX_OUTSTANDING(2)) dut_c (
      .clk_i(clk), .rst_i(rst), .stall_request_i(streq), .wb(if_c));

   logic        o_ack, o_err, o_stall;
   logic [31:0] o_dat;
   always_comb begin
      case (dsel)
         2'd1:    {o_ack, o_err, o_stall, o_dat} = {if_b.wb_ack_o, if_b.wb_err_o, if_b.wb_stall_o, if_b.wb_dat_o};
         2'd2:    {o_ack, o_err, o_stall, o_dat} = {if_c.wb_ack_o, if_c.wb_err_o, if_c.wb_stall_o, if_c.wb_dat_o};
         default: {o_ack, o_err, o_stall, o_dat} = {if_a.wb_ack_o, if_a.wb_err_o, if_a.wb_stall_o, if_a.wb_dat_o};
      endcase
   end

   typedef struct {
      bit          is_err;
      logic [31:0] dat;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   int          ack_cycles[$];
   logic [31:0] mdl [3][1024];
   logic [31:0] last_dat;
   int          m_lat, m_max, mcount, cyc_no, n_err;
   int          vectors = 0;
   int          miscompares = 0;
   bit          saw_stall;

   task automatic select(input logic [1:0] k, input int lat, input int max_out);
      dsel = k; m_lat = lat; m_max = max_out; mcount = 0;
      sbq.delete(); ack_cycles.delete(); saw_stall = 0; n_err = 0;
   endtask

   // One clock: drive inputs, check outputs against the model, advance the model past the edge.
   task automatic tick(input bit c, s, w, input logic [31:0] a, d, input logic [3:0] be,
                       input bit sr, r, output bit acc);
      bit   exp_stall, resp, inr;
      int   idx;
      exp_t e;
      cyc = c; stb = s; we = w; adr = a; wdat = d; sel = be; streq = sr; rst = r;
      #1;
      exp_stall = sr || (mcount == m_max);
      vectors++;
      if (o_stall !== exp_stall) begin
         miscompares++;
         $display("FAIL stall cycle %0d: got %b want %b", cyc_no, o_stall, exp_stall);
      end
      if (o_stall === 1'b1) saw_stall = 1;
      resp = 0;
      vectors++;
      if (sbq.size() > 0 && sbq[0].due == cyc_no) begin
         e = sbq.pop_front();
         resp = 1;
         if (o_ack !== !e.is_err || o_err !== e.is_err || o_dat !== e.dat) begin
            miscompares++;
            $display("FAIL response cycle %0d: got ack=%b err=%b dat=%h want ack=%b err=%b dat=%h",
                     cyc_no, o_ack, o_err, o_dat, !e.is_err, e.is_err, e.dat);
         end
         if (o_ack === 1'b1) begin ack_cycles.push_back(cyc_no); last_dat = o_dat; end
         if (o_err === 1'b1) n_err++;
      end else if (o_ack !== 1'b0 || o_err !== 1'b0 || o_dat !== 32'h0) begin
         miscompares++;
         $display("FAIL idle cycle %0d: got ack=%b err=%b dat=%h want 0 0 0", cyc_no, o_ack, o_err, o_dat);
      end
      acc = c && s && !exp_stall && !r;
      if (r || !c) begin
         sbq.delete();
         mcount = 0;
      end else begin
         if (acc) begin
            inr = (a >> 2) < 32'd1024;
            idx = int'(a[11:2]);
            e.is_err = !inr; e.dat = 32'h0; e.due = cyc_no + m_lat;
            if (inr && w) begin
               for (int b = 0; b < 4; b++) if (be[b]) mdl[dsel][idx][8*b +: 8] = d[8*b +: 8];
            end else if (inr) begin
               e.dat = mdl[dsel][idx];
            end
            sbq.push_back(e);
         end
         mcount = mcount + int'(acc) - int'(resp);
      end
      @(posedge clk);
      cyc_no++;
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, d, input logic [3:0] be);
      bit acc;
      tick(1, 1, 1, a, d, be, 0, 0, acc);
   endtask

   task automatic rd(input logic [31:0] a);
      bit acc;
      tick(1, 1, 0, a, 32'h0, 4'h0, 0, 0, acc);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) tick(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, acc);
   endtask

   task automatic test_reset;
      cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0; streq = 0; rst = 1; dsel = 0; cyc_no = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      select(0, 1, 4);
      #1;
      vectors++;
      if ({if_a.wb_ack_o, if_a.wb_err_o, if_a.wb_stall_o, if_a.wb_dat_o} !== 35'h0) begin
         miscompares++;
         $display("FAIL reset_a: got ack=%b err=%b stall=%b dat=%h want all 0",
                  if_a.wb_ack_o, if_a.wb_err_o, if_a.wb_stall_o, if_a.wb_dat_o);
      end
      vectors++;
      if ({if_b.wb_ack_o, if_c.wb_ack_o, if_b.wb_stall_o, if_c.wb_stall_o} !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_bc: got ack_b=%b ack_c=%b stall_b=%b stall_c=%b want 0",
                  if_b.wb_ack_o, if_c.wb_ack_o, if_b.wb_stall_o, if_c.wb_stall_o);
      end
      @(negedge clk);
   endtask

   task automatic test_defaults;
      select(0, 1, 4);
      wr(32'h10, 32'hDEADBEEF, 4'hF);
      rd(32'h10);
      idle(3);
      vectors++;
      if (ack_cycles.size() != 2 || last_dat !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL defaults: got %0d acks dat=%h want 2 acks dat=deadbeef", ack_cycles.size(), last_dat);
      end
   endtask

   task automatic test_byte_mask;
      select(0, 1, 4);
      wr(32'h10, 32'h11223344, 4'b0101);
      rd(32'h10);
      idle(2);
      vectors++;
      if (last_dat !== 32'hDE22BE44) begin
         miscompares++;
         $display("FAIL byte_mask: got %h want de22be44", last_dat);
      end
   endtask

   task automatic test_back_to_back;
      int start;
      select(1, 3, 4);
      for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'(i + 1), 4'hF);
      idle(5);
      ack_cycles.delete(); saw_stall = 0;
      start = cyc_no;
      for (int i = 0; i < 4; i++) rd(32'(i * 4));
      idle(5);
      vectors++;
      if (ack_cycles.size() != 4 || saw_stall || last_dat !== 32'd4) begin
         miscompares++;
         $display("FAIL b2b: got acks=%0d stall_seen=%b last=%h want 4 0 4", ack_cycles.size(), saw_stall, last_dat);
      end
      for (int i = 0; i < ack_cycles.size(); i++) begin
         vectors++;
         if (ack_cycles[i] != start + 3 + i) begin
            miscompares++;
            $display("FAIL b2b_timing %0d: got cycle %0d want %0d", i, ack_cycles[i], start + 3 + i);
         end
      end
   endtask

   task automatic test_stall_limit;
      int i, guard;
      bit acc;
      select(2, 4, 2);
      i = 0; guard = 0;
      while (i < 5 && guard < 60) begin
         tick(1, 1, 1, 32'(i * 4), 32'h100 + 32'(i), 4'hF, 0, 0, acc);
         if (acc) i++;
         guard++;
      end
      idle(6);
      ack_cycles.delete(); saw_stall = 0;
      i = 0; guard = 0;
      while (i < 5 && guard < 60) begin
         tick(1, 1, 0, 32'(i * 4), 32'h0, 4'h0, 0, 0, acc);
         if (acc) i++;
         guard++;
      end
      idle(6);
      vectors++;
      if (i != 5 || ack_cycles.size() != 5 || !saw_stall || last_dat !== 32'h104) begin
         miscompares++;
         $display("FAIL stall_limit: got accepted=%0d acks=%0d stall_seen=%b last=%h want 5 5 1 00000104",
                  i, ack_cycles.size(), saw_stall, last_dat);
      end
   endtask

   task automatic test_bus_error;
      select(0, 1, 4);
      wr(32'hFFC, 32'h5A5A5A5A, 4'hF);
      rd(32'hFFC);
      wr(32'h0, 32'hCAFEF00D, 4'hF);
      rd(32'h1000);
      wr(32'h1000, 32'hFFFFFFFF, 4'hF);
      rd(32'h0);
      idle(3);
      vectors++;
      if (n_err != 2 || last_dat !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL bus_error: got errs=%0d word0=%h want 2 cafef00d", n_err, last_dat);
      end
   endtask

   task automatic test_stall_request;
      bit acc;
      select(0, 1, 4);
      wr(32'h20, 32'h0BADC0DE, 4'hF);
      tick(1, 1, 0, 32'h20, 32'h0, 4'h0, 1, 0, acc);
      tick(1, 1, 0, 32'h20, 32'h0, 4'h0, 1, 0, acc);
      rd(32'h20);
      idle(2);
      vectors++;
      if (ack_cycles.size() != 2 || last_dat !== 32'h0BADC0DE) begin
         miscompares++;
         $display("FAIL stall_request: got acks=%0d dat=%h want 2 0badc0de", ack_cycles.size(), last_dat);
      end
   endtask

   task automatic test_abort;
      bit acc;
      select(1, 3, 4);
      rd(32'h0);
      rd(32'h4);
      tick(0, 1, 0, 32'h8, 32'h0, 4'h0, 0, 0, acc);
      idle(5);
      vectors++;
      if (ack_cycles.size() != 0 || n_err != 0 || o_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL abort: got acks=%0d errs=%0d stall=%b want 0 0 0", ack_cycles.size(), n_err, o_stall);
      end
      rd(32'h0);
      rd(32'h4);
      tick(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, acc);
      #1;
      vectors++;
      if ({o_ack, o_err, o_stall, o_dat} !== 35'h0) begin
         miscompares++;
         $display("FAIL reset_abort: got ack=%b err=%b stall=%b dat=%h want all 0", o_ack, o_err, o_stall, o_dat);
      end
      @(negedge clk);
      cyc_no++;
      idle(5);
      vectors++;
      if (ack_cycles.size() != 0 || n_err != 0) begin
         miscompares++;
         $display("FAIL reset_abort_late: got acks=%0d errs=%0d want 0 0", ack_cycles.size(), n_err);
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_byte_mask();
      test_back_to_back();
      test_stall_limit();
      test_bus_error();
      test_stall_request();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
